// File: rtl/ssd_pkg.sv
// Shared types and seven-segment glyph constants for the 3-digit BCD display scanner.
package ssd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 3;

  typedef enum logic [1:0] {
    SLOT_HUND = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_ONES = 2'd2
  } slot_t;

  // One captured display value: three BCD digits plus its leading-zero mode.
  typedef struct packed {
    logic [BCD_W-1:0] hundreds;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    logic             blank_lz;
  } bcd3_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd3_ssd_scanner_if.sv
// Load-side BCD triple and display-side scan outputs of the scanner.
interface bcd3_ssd_scanner_if;
  import ssd_pkg::*;

  logic             load;
  logic [BCD_W-1:0] hundreds;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;
  logic             blank_lz;
  logic [SEG_W-1:0] seg;
  logic [DIG_W-1:0] digit_en;
  logic             frame_done;

  modport master (
    output load, hundreds, tens, ones, blank_lz,
    input  seg, digit_en, frame_done
  );

  modport slave (
    input  load, hundreds, tens, ones, blank_lz,
    output seg, digit_en, frame_done
  );

endinterface

// File: rtl/bcd3_ssd_scanner_bcd_to_7seg.sv
// Combinational BCD digit to seven-segment glyph; non-decimal codes show a dash.
module bcd_to_7seg
  import ssd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_DASH;
    case (bcd)
      4'd0:    glyph_c = SEG_0;
      4'd1:    glyph_c = SEG_1;
      4'd2:    glyph_c = SEG_2;
      4'd3:    glyph_c = SEG_3;
      4'd4:    glyph_c = SEG_4;
      4'd5:    glyph_c = SEG_5;
      4'd6:    glyph_c = SEG_6;
      4'd7:    glyph_c = SEG_7;
      4'd8:    glyph_c = SEG_8;
      4'd9:    glyph_c = SEG_9;
      default: glyph_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd3_ssd_scanner.sv
// Time-multiplexed 3-digit seven-segment scanner with shadowed, frame-aligned
// display updates, per-slot anti-ghost blanking and optional leading-zero blanking.
module bcd3_ssd_scanner
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYC      = 16,
  parameter bit          ACTIVE_LOW_SEG = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  bcd3_ssd_scanner_if.slave   bus
);

  localparam int unsigned      CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(SCAN_DIV - 2);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [SEG_W-1:0] SEG_DARK  = ACTIVE_LOW_SEG ? ~SEG_OFF : SEG_OFF;

  slot_t            slot;
  logic [CNT_W-1:0] cnt;

  bcd3_t            shadow;
  bcd3_t            display;
  logic             pending;

  logic [SEG_W-1:0] seg_q;
  logic [DIG_W-1:0] digit_en_q;
  logic             frame_done_q;

  bcd3_t            incoming_c;
  logic             frame_end_c;
  logic [BCD_W-1:0] cur_digit_c;
  logic [DIG_W-1:0] slot_onehot_c;
  logic             dark_c;
  logic [SEG_W-1:0] glyph_c;
  logic [SEG_W-1:0] seg_nxt_c;
  logic [DIG_W-1:0] digit_en_nxt_c;

  assign incoming_c  = {bus.hundreds, bus.tens, bus.ones, bus.blank_lz};
  assign frame_end_c = (slot == SLOT_ONES) && (cnt == CNT_LAST);

  // Digit selection, slot position and blanking for the state currently scanned.
  always_comb begin
    cur_digit_c   = display.ones;
    slot_onehot_c = 3'b001;
    dark_c        = (cnt < BLANK_END);
    case (slot)
      SLOT_HUND: begin
        cur_digit_c   = display.hundreds;
        slot_onehot_c = 3'b100;
        dark_c        = dark_c || (display.blank_lz && (display.hundreds == 4'd0));
      end
      SLOT_TENS: begin
        cur_digit_c   = display.tens;
        slot_onehot_c = 3'b010;
        dark_c        = dark_c || (display.blank_lz && (display.hundreds == 4'd0)
                                                   && (display.tens == 4'd0));
      end
      default: begin
        cur_digit_c   = display.ones;
        slot_onehot_c = 3'b001;
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd     (cur_digit_c),
    .glyph_c (glyph_c)
  );

  always_comb begin
    seg_nxt_c      = SEG_DARK;
    digit_en_nxt_c = '0;
    if (!dark_c) begin
      seg_nxt_c      = ACTIVE_LOW_SEG ? ~glyph_c : glyph_c;
      digit_en_nxt_c = slot_onehot_c;
    end
  end

  // Slot counter and slot FSM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot <= SLOT_HUND;
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      case (slot)
        SLOT_HUND: slot <= SLOT_TENS;
        SLOT_TENS: slot <= SLOT_ONES;
        default:   slot <= SLOT_HUND;
      endcase
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Shadow capture and frame-boundary commit; a load on the boundary goes straight through.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else if (frame_end_c) begin
      if (bus.load) begin
        display <= incoming_c;
      end else if (pending) begin
        display <= shadow;
      end
      pending <= 1'b0;
    end else if (bus.load) begin
      shadow  <= incoming_c;
      pending <= 1'b1;
    end
  end

  // frame_done is looked ahead one cycle so it is high in the same cycle as the commit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      seg_q        <= SEG_DARK;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_nxt_c;
      digit_en_q   <= digit_en_nxt_c;
      frame_done_q <= (slot == SLOT_ONES) && (cnt == CNT_PRE);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd3_ssd_scanner.sv
// Bench for bcd3_ssd_scanner: cycle-level reference model plus hand-checked vectors.
module tb_bcd3_ssd_scanner;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 3 * SD;

  logic clk;
  logic n_rst;

  bcd3_ssd_scanner_if bus1 ();
  bcd3_ssd_scanner_if bus2 ();

  bcd3_ssd_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW_SEG(1'b0)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus1));

  bcd3_ssd_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW_SEG(1'b1)) dut_al (
    .clk(clk), .n_rst(n_rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: absolute cycle count since reset gives slot and counter directly.
  int         t;
  int         prev_pos;
  logic [3:0] m_disp [0:2];
  logic [3:0] m_sh   [0:2];
  logic       m_blz, m_sh_blz, m_pend;
  logic [6:0] exp_seg;
  logic [2:0] exp_en;
  logic       exp_fd;
  logic [6:0] glyph_tbl [0:9];

  typedef struct {
    logic [3:0]       h, tn, o;
    logic             blz;
    logic [0:2][6:0]  seg;
    logic [0:2][2:0]  en;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [6:0] m_glyph(input logic [3:0] v);
    return (v <= 4'd9) ? glyph_tbl[v] : 7'h40;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; prev_pos = 0;
    for (int i = 0; i < 3; i++) begin m_disp[i] = 4'd0; m_sh[i] = 4'd0; end
    m_blz = 1'b0; m_sh_blz = 1'b0; m_pend = 1'b0;
    exp_seg = 7'h00; exp_en = 3'b000; exp_fd = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [3:0] h, tn, o, input logic blz);
    int  pos, s, c;
    logic dark;
    pos  = t % FRAME;
    s    = pos / SD;
    c    = pos % SD;
    dark = (c < BC)
        || (m_blz && s == 0 && m_disp[0] == 4'd0)
        || (m_blz && s == 1 && m_disp[0] == 4'd0 && m_disp[1] == 4'd0);
    exp_en   = dark ? 3'b000 : 3'(4 >> s);
    exp_seg  = dark ? 7'h00 : m_glyph(m_disp[s]);
    prev_pos = pos;
    if (pos == FRAME - 1) begin
      if (ld) begin
        m_disp[0] = h; m_disp[1] = tn; m_disp[2] = o; m_blz = blz;
      end else if (m_pend) begin
        m_disp = m_sh; m_blz = m_sh_blz;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh[0] = h; m_sh[1] = tn; m_sh[2] = o; m_sh_blz = blz; m_pend = 1'b1;
    end
    t++;
    exp_fd = ((t % FRAME) == FRAME - 1);
  endtask

  // One clock: drive inputs (called at negedge), step model, compare #1 after the edge.
  task automatic cycle(input logic ld, input logic [3:0] h, tn, o, input logic blz);
    bus1.load = ld; bus1.hundreds = h; bus1.tens = tn; bus1.ones = o; bus1.blank_lz = blz;
    @(posedge clk);
    model_edge(ld, h, tn, o, blz);
    #1;
    check("seg",        8'(bus1.seg),        8'(exp_seg));
    check("digit_en",   8'(bus1.digit_en),   8'(exp_en));
    check("frame_done", 8'(bus1.frame_done), 8'(exp_fd));
    @(negedge clk);
    bus1.load = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) idle();
  endtask

  initial begin
    glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vecs[0] = '{4'd1, 4'd2, 4'd8, 1'b0, {7'h06, 7'h5B, 7'h7F}, {3'b100, 3'b010, 3'b001}};
    vecs[1] = '{4'd0, 4'd0, 4'd7, 1'b1, {7'h00, 7'h00, 7'h07}, {3'b000, 3'b000, 3'b001}};
    vecs[2] = '{4'd0, 4'd0, 4'd7, 1'b0, {7'h3F, 7'h3F, 7'h07}, {3'b100, 3'b010, 3'b001}};
    vecs[3] = '{4'd0, 4'hA, 4'd3, 1'b1, {7'h00, 7'h40, 7'h4F}, {3'b000, 3'b010, 3'b001}};
    vecs[4] = '{4'd0, 4'd5, 4'd0, 1'b1, {7'h00, 7'h6D, 7'h3F}, {3'b000, 3'b010, 3'b001}};
    vecs[5] = '{4'hF, 4'd0, 4'd0, 1'b1, {7'h40, 7'h3F, 7'h3F}, {3'b100, 3'b010, 3'b001}};
    vecs[6] = '{4'd0, 4'd0, 4'd0, 1'b1, {7'h00, 7'h00, 7'h3F}, {3'b000, 3'b000, 3'b001}};

    bus1.load = 1'b0; bus1.hundreds = 4'd0; bus1.tens = 4'd0; bus1.ones = 4'd0; bus1.blank_lz = 1'b0;
    bus2.load = 1'b0; bus2.hundreds = 4'd0; bus2.tens = 4'd0; bus2.ones = 4'd0; bus2.blank_lz = 1'b0;
    n_rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_seg",      8'(bus1.seg),        8'h00);
    check("reset_en",       8'(bus1.digit_en),   8'h00);
    check("reset_fd",       8'(bus1.frame_done), 8'h00);
    check("reset_seg_al",   8'(bus2.seg),        8'h7F);
    n_rst = 1'b1;

    // Power-up display 000 over two frames; the active-low unit gets 8/8/8 queued.
    bus2.load = 1'b1; bus2.hundreds = 4'd8; bus2.tens = 4'd8; bus2.ones = 4'd8;
    idle();
    bus2.load = 1'b0;
    for (int i = 1; i < 2 * FRAME; i++) idle();
    check("first_lit_en", 8'(bus1.digit_en), 8'b001);

    run_to(1);
    idle();
    check("al_dark_seg", 8'(bus2.seg),      8'h7F);
    check("al_dark_en",  8'(bus2.digit_en), 8'h00);
    run_to(4);
    idle();
    check("al_lit_seg",  8'(bus2.seg),      8'h00);
    check("al_lit_en",   8'(bus2.digit_en), 8'b100);

    // Table vectors: load mid-frame, check the mid-slot glyph of the following frame.
    for (int v = 0; v < 7; v++) begin
      run_to(5);
      cycle(1'b1, vecs[v].h, vecs[v].tn, vecs[v].o, vecs[v].blz);
      run_to(0);
      for (int i = 0; i < FRAME; i++) begin
        idle();
        if (i % SD == 4) begin
          check($sformatf("vec%0d_seg%0d", v, i / SD), 8'(bus1.seg),      8'(vecs[v].seg[i / SD]));
          check($sformatf("vec%0d_en%0d",  v, i / SD), 8'(bus1.digit_en), 8'(vecs[v].en[i / SD]));
        end
      end
    end

    // Load on the frame_done cycle bypasses the shadow.
    run_to(FRAME - 1);
    check("fd_high", 8'(bus1.frame_done), 8'h01);
    cycle(1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
    for (int i = 1; i < FRAME; i++) begin
      idle();
      if (i % SD == 4) check("bypass_seg", 8'(bus1.seg), 8'h6F);
    end

    // Two loads in one frame: the last one wins.
    run_to(3);
    cycle(1'b1, 4'd5, 4'd5, 4'd5, 1'b0);
    run_to(10);
    cycle(1'b1, 4'd6, 4'd6, 4'd6, 1'b0);
    run_to(0);
    for (int i = 0; i < FRAME; i++) begin
      idle();
      if (i % SD == 4) check("last_wins_seg", 8'(bus1.seg), 8'h7D);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       ld, blz;
      logic [3:0] d [0:2];
      ld  = ($urandom_range(0, 5) == 0);
      blz = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++)
        d[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      cycle(ld, d[0], d[1], d[2], blz);
    end

    // Asynchronous reset in the tens slot, counter 5.
    run_to(3);
    cycle(1'b1, 4'd4, 4'd4, 4'd4, 1'b0);
    run_to(13);
    n_rst = 1'b0;
    #1;
    check("mid_rst_seg", 8'(bus1.seg),        8'h00);
    check("mid_rst_en",  8'(bus1.digit_en),   8'h00);
    check("mid_rst_fd",  8'(bus1.frame_done), 8'h00);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    n_rst = 1'b1;
    idle();
    idle();
    idle();
    check("post_rst_en",  8'(bus1.digit_en), 8'b100);
    check("post_rst_seg", 8'(bus1.seg),      8'h3F);
    for (int i = 0; i < 2 * FRAME; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
